// File: rtl/haar_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | haar_pkg : shared FSM state type and sizing helper for the Haar cascade |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package haar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } haar_state_t;

  // Stage index must also encode NUM_STAGE itself ("no stage failed").
  function automatic int stage_idx_w(input int num_stage);
    return $clog2(num_stage + 1);
  endfunction

endpackage : haar_pkg
`default_nettype wire

// File: rtl/haar_sat_accumulator.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | haar_sat_accumulator : signed accumulator that clamps at ACC_WIDTH      |
// | max/min instead of wrapping.                                             |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module haar_sat_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_enable,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic signed [ACC_WIDTH-1:0]  o_acc
);

  localparam logic signed [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_data_ext;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic signed [ACC_WIDTH-1:0] w_sat;

  assign w_data_ext = ACC_WIDTH'(i_data);
  assign w_sum      = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_data_ext);

  // One guard bit: the top two bits differ only on overflow, and the guard bit
  // gives the true sign of the result.
  always_comb begin
    w_sat = w_sum[ACC_WIDTH-1:0];
    if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
      w_sat = w_sum[ACC_WIDTH] ? c_acc_min : c_acc_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= w_sat;
    end
  end

  assign o_acc = r_acc;

endmodule : haar_sat_accumulator
`default_nettype wire

// File: rtl/haar_cascade_evaluator.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | haar_cascade_evaluator : accumulates tree votes per cascade stage,      |
// | compares against stage thresholds and reports the window verdict.       |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module haar_cascade_evaluator
  import haar_pkg::*;
#(
  parameter int  DATA_WIDTH_16 = 16,
  parameter int  NUM_STAGE     = 10,
  parameter int  ACC_WIDTH     = 24,
  parameter bit  EARLY_EXIT    = 1'b1,
  localparam int STAGE_IDX_W   = stage_idx_w(NUM_STAGE)
) (
  input  logic                               clk_fpga,
  input  logic                               reset_fpga,
  input  logic                               i_window_start,
  input  logic                               i_vote_valid,
  output logic                               o_vote_ready,
  input  logic signed [DATA_WIDTH_16-1:0]    i_vote,
  input  logic                               i_vote_last,
  input  logic [NUM_STAGE*DATA_WIDTH_16-1:0] i_threshold,
  output logic [STAGE_IDX_W-1:0]             o_stage_index,
  output logic                               o_flush,
  output logic                               o_busy,
  output logic [NUM_STAGE-1:0]               o_pass_mask,
  output logic [STAGE_IDX_W-1:0]             o_reject_stage,
  output logic                               o_candidate,
  output logic                               o_inspect_done
);

  localparam logic [STAGE_IDX_W-1:0] c_no_reject  = STAGE_IDX_W'(NUM_STAGE);
  localparam logic [STAGE_IDX_W-1:0] c_last_stage = STAGE_IDX_W'(NUM_STAGE - 1);

  haar_state_t r_state;
  haar_state_t w_next;

  logic [STAGE_IDX_W-1:0]      r_stage_idx;
  logic [NUM_STAGE-1:0]        r_pass_mask;
  logic [STAGE_IDX_W-1:0]      r_reject;
  logic                        r_candidate;
  logic                        r_flush;
  logic                        r_inspect_done;
  logic                        r_busy;
  logic                        r_vote_ready;

  logic                        w_handshake;
  logic                        w_start;
  logic                        w_advance;
  logic                        w_flush;
  logic                        w_pass;
  logic                        w_last_stage;
  logic                        w_acc_clear;
  logic [NUM_STAGE-1:0]        w_mask_upd;
  logic signed [DATA_WIDTH_16-1:0] w_thr;
  logic signed [ACC_WIDTH-1:0] w_thr_ext;
  logic signed [ACC_WIDTH-1:0] w_acc;

  // Ready is registered and only ever high in ACCUM, so it also gates votes.
  assign w_handshake  = i_vote_valid & r_vote_ready;
  assign w_start      = (r_state == IDLE) & i_window_start;
  assign w_last_stage = (r_stage_idx == c_last_stage);
  assign w_acc_clear  = w_start | w_advance;

  assign w_thr     = i_threshold[int'(r_stage_idx)*DATA_WIDTH_16 +: DATA_WIDTH_16];
  assign w_thr_ext = ACC_WIDTH'(w_thr);
  assign w_pass    = (w_acc >= w_thr_ext);

  always_comb begin
    w_mask_upd              = r_pass_mask;
    w_mask_upd[r_stage_idx] = w_pass;
  end

  haar_sat_accumulator #(
    .DATA_WIDTH (DATA_WIDTH_16),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .clk      (clk_fpga),
    .rst_n    (reset_fpga),
    .i_clear  (w_acc_clear),
    .i_enable (w_handshake),
    .i_data   (i_vote),
    .o_acc    (w_acc)
  );

  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    w_flush   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_window_start) w_next = ACCUM;
      end
      ACCUM: begin
        if (w_handshake && i_vote_last) w_next = COMPARE;
      end
      COMPARE: begin
        if (w_last_stage) begin
          w_next = DONE;
        end else if (!w_pass && EARLY_EXIT) begin
          w_next  = DONE;
          w_flush = 1'b1;
        end else begin
          w_next    = ACCUM;
          w_advance = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Status outputs are derived from the next state so they line up with it.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      r_state        <= IDLE;
      r_stage_idx    <= '0;
      r_pass_mask    <= '0;
      r_reject       <= c_no_reject;
      r_candidate    <= 1'b0;
      r_flush        <= 1'b0;
      r_inspect_done <= 1'b0;
      r_busy         <= 1'b0;
      r_vote_ready   <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_vote_ready   <= (w_next == ACCUM);
      r_busy         <= (w_next != IDLE);
      r_flush        <= w_flush;
      r_inspect_done <= (r_state == COMPARE) && (w_next == DONE);

      if (w_start) begin
        r_stage_idx <= '0;
        r_pass_mask <= '0;
        r_candidate <= 1'b0;
        r_reject    <= c_no_reject;
      end

      if (r_state == COMPARE) begin
        r_pass_mask <= w_mask_upd;
        if (!w_pass && (r_reject == c_no_reject)) begin
          r_reject <= r_stage_idx;
        end
        if (w_advance) begin
          r_stage_idx <= r_stage_idx + STAGE_IDX_W'(1);
        end else begin
          r_candidate <= &w_mask_upd;
        end
      end
    end
  end

  assign o_vote_ready   = r_vote_ready;
  assign o_busy         = r_busy;
  assign o_stage_index  = r_stage_idx;
  assign o_pass_mask    = r_pass_mask;
  assign o_reject_stage = r_reject;
  assign o_candidate    = r_candidate;
  assign o_flush        = r_flush;
  assign o_inspect_done = r_inspect_done;

endmodule : haar_cascade_evaluator
`default_nettype wire

// File: tb/tb_haar_cascade_evaluator.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_haar_cascade_evaluator : directed self-checking bench, three stages, |
// | thresholds {10, 0, -5}; early-exit, full-evaluation and 16-bit variants.|
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_haar_cascade_evaluator;

  logic        clk;
  logic        rst_n;
  logic        win_start;
  logic        vote_valid;
  logic signed [15:0] vote;
  logic        vote_last;
  logic [47:0] thr;

  logic       ready_a, flush_a, busy_a, cand_a, done_a;
  logic [1:0] idx_a, rej_a;
  logic [2:0] mask_a;
  logic       ready_b, flush_b, busy_b, cand_b, done_b;
  logic [1:0] idx_b, rej_b;
  logic [2:0] mask_b;
  logic       ready_c, flush_c, busy_c, cand_c, done_c;
  logic [1:0] idx_c, rej_c;
  logic [2:0] mask_c;

  int   sel;
  logic ready_sel;
  int   checks;
  int   errors;
  int   done_cnt_a;
  bit   flush_b_seen;

  assign ready_sel = (sel == 0) ? ready_a : (sel == 1) ? ready_b : ready_c;

  haar_cascade_evaluator #(.DATA_WIDTH_16(16), .NUM_STAGE(3), .ACC_WIDTH(24), .EARLY_EXIT(1'b1)) dut_a (
    .clk_fpga(clk), .reset_fpga(rst_n), .i_window_start(win_start), .i_vote_valid(vote_valid),
    .o_vote_ready(ready_a), .i_vote(vote), .i_vote_last(vote_last), .i_threshold(thr),
    .o_stage_index(idx_a), .o_flush(flush_a), .o_busy(busy_a), .o_pass_mask(mask_a),
    .o_reject_stage(rej_a), .o_candidate(cand_a), .o_inspect_done(done_a));

  haar_cascade_evaluator #(.DATA_WIDTH_16(16), .NUM_STAGE(3), .ACC_WIDTH(24), .EARLY_EXIT(1'b0)) dut_b (
    .clk_fpga(clk), .reset_fpga(rst_n), .i_window_start(win_start), .i_vote_valid(vote_valid),
    .o_vote_ready(ready_b), .i_vote(vote), .i_vote_last(vote_last), .i_threshold(thr),
    .o_stage_index(idx_b), .o_flush(flush_b), .o_busy(busy_b), .o_pass_mask(mask_b),
    .o_reject_stage(rej_b), .o_candidate(cand_b), .o_inspect_done(done_b));

  haar_cascade_evaluator #(.DATA_WIDTH_16(16), .NUM_STAGE(3), .ACC_WIDTH(16), .EARLY_EXIT(1'b1)) dut_c (
    .clk_fpga(clk), .reset_fpga(rst_n), .i_window_start(win_start), .i_vote_valid(vote_valid),
    .o_vote_ready(ready_c), .i_vote(vote), .i_vote_last(vote_last), .i_threshold(thr),
    .o_stage_index(idx_c), .o_flush(flush_c), .o_busy(busy_c), .o_pass_mask(mask_c),
    .o_reject_stage(rej_c), .o_candidate(cand_c), .o_inspect_done(done_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a = done_cnt_a + 1;
    if (flush_b === 1'b1) flush_b_seen = 1'b1;
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    win_start = 1'b0; vote_valid = 1'b0; vote_last = 1'b0; vote = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_window();
    win_start = 1'b1;
    tick();
    win_start = 1'b0;
  endtask

  // Holds the vote until ready is seen, then lets the handshake edge pass.
  task automatic send_vote(input logic signed [15:0] v, input logic last);
    int n;
    n = 0;
    vote_valid = 1'b1; vote = v; vote_last = last;
    while (ready_sel !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (ready_sel !== 1'b1) begin
      errors++;
      $display("FAIL vote_ready_timeout got=%b want=1", ready_sel);
    end
    tick();
    vote_valid = 1'b0; vote_last = 1'b0; vote = '0;
  endtask

  task automatic test_reset();
    sel = 0;
    rst_n = 1'b1; win_start = 1'b0; vote_valid = 1'b0; vote_last = 1'b0; vote = '0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_a, busy_a, flush_a, done_a} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0000", {ready_a, busy_a, flush_a, done_a});
    end
    checks++;
    if ({idx_a, mask_a, rej_a, cand_a} !== {2'd0, 3'b000, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL reset_result got=%b want=%b", {idx_a, mask_a, rej_a, cand_a}, {2'd0, 3'b000, 2'd3, 1'b0});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_all_pass();
    sel = 0;
    apply_reset();
    start_window();
    checks++;
    if ({busy_a, ready_a, mask_a, rej_a} !== {1'b1, 1'b1, 3'b000, 2'd3}) begin
      errors++;
      $display("FAIL start_state got=%b want=%b", {busy_a, ready_a, mask_a, rej_a}, {1'b1, 1'b1, 3'b000, 2'd3});
    end
    send_vote(16'sd4, 1'b0);
    send_vote(16'sd6, 1'b1);
    checks++;
    if (ready_a !== 1'b0) begin
      errors++;
      $display("FAIL compare_ready got=%b want=0", ready_a);
    end
    send_vote(16'sd1, 1'b0);
    checks++;
    if (idx_a !== 2'd1) begin
      errors++;
      $display("FAIL stage_index_1 got=%0d want=1", idx_a);
    end
    send_vote(-16'sd1, 1'b1);
    send_vote(-16'sd5, 1'b1);
    // Handshake cycle N: COMPARE in N+1, verdict in N+2.
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL done_early got=%b want=0", done_a);
    end
    tick();
    checks++;
    if ({done_a, mask_a, cand_a, rej_a, flush_a} !== {1'b1, 3'b111, 1'b1, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL all_pass_verdict got=%b want=%b", {done_a, mask_a, cand_a, rej_a, flush_a}, {1'b1, 3'b111, 1'b1, 2'd3, 1'b0});
    end
    tick();
    checks++;
    if ({done_a, busy_a, mask_a, cand_a} !== {1'b0, 1'b0, 3'b111, 1'b1}) begin
      errors++;
      $display("FAIL all_pass_after got=%b want=%b", {done_a, busy_a, mask_a, cand_a}, {1'b0, 1'b0, 3'b111, 1'b1});
    end
  endtask

  task automatic test_early_exit();
    sel = 0;
    apply_reset();
    start_window();
    send_vote(16'sd4, 1'b0);
    send_vote(16'sd5, 1'b1);
    vote_valid = 1'b1; vote = 16'sd9; vote_last = 1'b1;
    tick();
    checks++;
    if ({flush_a, done_a, mask_a, rej_a, cand_a, ready_a} !== {1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL early_exit_verdict got=%b want=%b", {flush_a, done_a, mask_a, rej_a, cand_a, ready_a}, {1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({flush_a, ready_a, busy_a, idx_a} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
        errors++;
        $display("FAIL early_exit_no_accept cyc=%0d got=%b want=%b", i, {flush_a, ready_a, busy_a, idx_a}, {1'b0, 1'b0, 1'b0, 2'd0});
      end
    end
    vote_valid = 1'b0; vote_last = 1'b0; vote = '0;
  endtask

  task automatic test_no_early_exit();
    sel = 1;
    apply_reset();
    start_window();
    send_vote(16'sd4, 1'b0);
    send_vote(16'sd5, 1'b1);
    send_vote(16'sd0, 1'b1);
    checks++;
    if (idx_b !== 2'd1) begin
      errors++;
      $display("FAIL full_eval_stage1 got=%0d want=1", idx_b);
    end
    send_vote(-16'sd5, 1'b1);
    tick();
    checks++;
    if ({done_b, mask_b, rej_b, cand_b, flush_b} !== {1'b1, 3'b110, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL full_eval_verdict got=%b want=%b", {done_b, mask_b, rej_b, cand_b, flush_b}, {1'b1, 3'b110, 2'd0, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if (flush_b_seen !== 1'b0) begin
      errors++;
      $display("FAIL full_eval_flush got=%b want=0", flush_b_seen);
    end
  endtask

  task automatic test_saturation();
    sel = 2;
    apply_reset();
    start_window();
    send_vote(16'sh7FFF, 1'b0);
    send_vote(16'sd100, 1'b1);
    checks++;
    if (dut_c.u_acc.o_acc !== 16'sh7FFF) begin
      errors++;
      $display("FAIL sat_pos_acc got=%h want=7fff", dut_c.u_acc.o_acc);
    end
    send_vote(16'sd0, 1'b1);
    send_vote(-16'sd5, 1'b1);
    tick();
    checks++;
    if ({done_c, mask_c, cand_c} !== {1'b1, 3'b111, 1'b1}) begin
      errors++;
      $display("FAIL sat_pos_verdict got=%b want=%b", {done_c, mask_c, cand_c}, {1'b1, 3'b111, 1'b1});
    end
    tick();
    start_window();
    send_vote(16'sh8000, 1'b0);
    send_vote(-16'sd1, 1'b1);
    checks++;
    if (dut_c.u_acc.o_acc !== 16'sh8000) begin
      errors++;
      $display("FAIL sat_neg_acc got=%h want=8000", dut_c.u_acc.o_acc);
    end
    tick();
    checks++;
    if ({done_c, flush_c, mask_c, rej_c} !== {1'b1, 1'b1, 3'b000, 2'd0}) begin
      errors++;
      $display("FAIL sat_neg_verdict got=%b want=%b", {done_c, flush_c, mask_c, rej_c}, {1'b1, 1'b1, 3'b000, 2'd0});
    end
    tick();
  endtask

  task automatic test_start_ignored();
    sel = 0;
    apply_reset();
    start_window();
    send_vote(16'sd4, 1'b0);
    send_vote(16'sd6, 1'b1);
    send_vote(16'sd1, 1'b0);
    start_window();
    checks++;
    if ({idx_a, busy_a, ready_a, mask_a} !== {2'd1, 1'b1, 1'b1, 3'b001}) begin
      errors++;
      $display("FAIL start_in_accum got=%b want=%b", {idx_a, busy_a, ready_a, mask_a}, {2'd1, 1'b1, 1'b1, 3'b001});
    end
    send_vote(-16'sd1, 1'b1);
    send_vote(-16'sd5, 1'b1);
    tick();
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL start_done_cycle got=%b want=1", done_a);
    end
    start_window();
    checks++;
    if ({busy_a, ready_a, idx_a, mask_a, cand_a, rej_a} !== {1'b0, 1'b0, 2'd2, 3'b111, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL start_in_done got=%b want=%b", {busy_a, ready_a, idx_a, mask_a, cand_a, rej_a}, {1'b0, 1'b0, 2'd2, 3'b111, 1'b1, 2'd3});
    end
    tick();
    tick();
    tick();
    checks++;
    if ({busy_a, mask_a, cand_a, rej_a} !== {1'b0, 3'b111, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL verdict_hold got=%b want=%b", {busy_a, mask_a, cand_a, rej_a}, {1'b0, 3'b111, 1'b1, 2'd3});
    end
  endtask

  task automatic test_reset_midwindow();
    int saved_done;
    sel = 0;
    apply_reset();
    start_window();
    send_vote(16'sd4, 1'b0);
    send_vote(16'sd6, 1'b1);
    send_vote(16'sd1, 1'b0);
    saved_done = done_cnt_a;
    vote_valid = 1'b1; vote = 16'sd7; vote_last = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_a, busy_a, idx_a, mask_a, rej_a, cand_a, flush_a, done_a} !==
        {1'b0, 1'b0, 2'd0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midwindow got=%b want=%b", {ready_a, busy_a, idx_a, mask_a, rej_a, cand_a, flush_a, done_a},
               {1'b0, 1'b0, 2'd0, 3'b000, 2'd3, 1'b0, 1'b0, 1'b0});
    end
    tick();
    tick();
    vote_valid = 1'b0; vote_last = 1'b0; vote = '0;
    rst_n = 1'b1;
    win_start = 1'b1;
    tick();
    win_start = 1'b0;
    checks++;
    if ({busy_a, ready_a} !== 2'b11) begin
      errors++;
      $display("FAIL start_after_release got=%b want=11", {busy_a, ready_a});
    end
    checks++;
    if (done_cnt_a !== saved_done) begin
      errors++;
      $display("FAIL abandoned_window_done got=%0d want=%0d", done_cnt_a, saved_done);
    end
    send_vote(16'sd4, 1'b0);
    send_vote(16'sd6, 1'b1);
    send_vote(16'sd1, 1'b0);
    send_vote(-16'sd1, 1'b1);
    send_vote(-16'sd5, 1'b1);
    tick();
    checks++;
    if ({done_a, mask_a, cand_a, rej_a} !== {1'b1, 3'b111, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL post_reset_window got=%b want=%b", {done_a, mask_a, cand_a, rej_a}, {1'b1, 3'b111, 1'b1, 2'd3});
    end
    tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    done_cnt_a   = 0;
    flush_b_seen = 1'b0;
    sel          = 0;
    rst_n        = 1'b1;
    win_start    = 1'b0;
    vote_valid   = 1'b0;
    vote_last    = 1'b0;
    vote         = '0;
    thr          = {-16'sd5, 16'sd0, 16'sd10};

    test_reset();
    test_all_pass();
    test_early_exit();
    test_no_early_exit();
    test_saturation();
    test_start_ignored();
    test_reset_midwindow();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_haar_cascade_evaluator
`default_nettype wire

// File: doc/haar_cascade_evaluator.md
HAAR_CASCADE_EVALUATOR -- requirements
Module: haar_cascade_evaluator

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH_16, 16, signed vote and threshold width.
- NUM_STAGE, 10, cascade stage count (at least 1).
- ACC_WIDTH, 24, signed stage-accumulator width (at least DATA_WIDTH_16).
- EARLY_EXIT, 1, 1 = stop at first failing stage; 0 = evaluate all stages.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_fpga, in, 1, single clock.
- reset_fpga, in, 1, asynchronous active-low reset.
- i_window_start, in, 1, pulse: new integral window ready.
- i_vote_valid, in, 1, tree vote valid.
- o_vote_ready, out, 1, evaluator accepts vote.
- i_vote, in, DATA_WIDTH_16, signed tree vote.
- i_vote_last, in, 1, vote is last tree of current stage.
- i_threshold, in, NUM_STAGE*DATA_WIDTH_16, signed stage thresholds; stage s at [s*DATA_WIDTH_16 +: DATA_WIDTH_16].
- o_stage_index, out, STAGE_IDX_W, stage currently accumulating.
- o_flush, out, 1, pulse: feeder discards remaining votes of the window.
- o_busy, out, 1, window in progress.
- o_pass_mask, out, NUM_STAGE, per-stage pass bits.
- o_reject_stage, out, STAGE_IDX_W, first failing stage; NUM_STAGE when none failed.
- o_candidate, out, 1, window passed all stages.
- o_inspect_done, out, 1, one-cycle pulse: window verdict valid.

REQ-003 STAGE_IDX_W SHALL be $clog2(NUM_STAGE+1).

Function
REQ-004 FSM states SHALL be IDLE, ACCUM, COMPARE, DONE.
REQ-005 IDLE: o_vote_ready=0, o_busy=0. i_window_start=1 SHALL move to ACCUM, and SHALL clear the accumulator, o_stage_index, o_pass_mask, o_candidate and o_flush, and set o_reject_stage to NUM_STAGE.
REQ-006 ACCUM: o_vote_ready=1, o_busy=1. Each handshake (i_vote_valid & o_vote_ready) SHALL add sign-extended i_vote to the accumulator.
REQ-007 Accumulation SHALL saturate at the signed ACC_WIDTH max/min and SHALL NOT wrap.
REQ-008 A handshake with i_vote_last=1 SHALL include that vote and move to COMPARE on the next edge.
REQ-009 COMPARE (one cycle, o_vote_ready=0) SHALL set pass = (accumulator >= sign-extended threshold[o_stage_index]) and write o_pass_mask[o_stage_index] = pass.
REQ-010 A failing stage SHALL load o_reject_stage with o_stage_index if o_reject_stage still equals NUM_STAGE.
REQ-011 COMPARE exits:
- Last stage: go to DONE.
- !pass with EARLY_EXIT=1: assert o_flush for one cycle and go to DONE.
- Otherwise: increment o_stage_index, clear the accumulator, return to ACCUM.
REQ-012 DONE (one cycle) SHALL assert o_inspect_done, set o_candidate = &o_pass_mask (including the current write), and return to IDLE.
REQ-013 Latency from the last-vote handshake to o_inspect_done SHALL be exactly 2 cycles.
REQ-014 o_candidate, o_pass_mask and o_reject_stage SHALL hold their values until the next accepted i_window_start.
REQ-015 i_window_start outside IDLE SHALL be ignored, including the DONE cycle.
REQ-016 i_vote_valid outside ACCUM SHALL be ignored; no vote is consumed.
REQ-017 A zero-width stage (i_vote_last on the first vote) SHALL be legal.
REQ-018 With EARLY_EXIT=0, every stage SHALL be evaluated, o_flush SHALL never assert, and o_reject_stage SHALL report the first failing stage.

Reset
REQ-019 Asserting reset_fpga low SHALL immediately force: state=IDLE, accumulator=0, o_stage_index=0, o_pass_mask=0, o_reject_stage=NUM_STAGE, o_candidate=0, o_flush=0, o_inspect_done=0, o_busy=0, o_vote_ready=0.
REQ-020 Reset mid-window SHALL abandon the window with no o_inspect_done.
REQ-021 Deassertion SHALL be synchronised externally; the block SHALL accept i_window_start on the first edge after release.

Structure
REQ-022 Package haar_pkg SHALL hold the FSM state enum and the STAGE_IDX_W width function.
REQ-023 Saturating add SHALL be a sub-module haar_sat_accumulator (parameter ACC_WIDTH; clear, enable, signed input).
REQ-024 All outputs SHALL be registered.

Verification
Bench parameters: NUM_STAGE=3, thresholds {10, 0, -5}, EARLY_EXIT=1 unless stated.

REQ-025 Votes {4,6}|{1,-1}|{-5}, each stage last-terminated -> o_pass_mask=3'b111, o_candidate=1, o_reject_stage=3, o_inspect_done exactly 2 cycles after the final handshake.
REQ-026 Stage-0 votes {4,5} -> o_flush pulse, o_pass_mask=3'b000, o_reject_stage=0, o_candidate=0, no stage-1 vote accepted.
REQ-027 Same as REQ-026 with EARLY_EXIT=0, then {0}|{-5} -> o_pass_mask=3'b110, o_reject_stage=0, o_candidate=0, o_flush never asserted.
REQ-028 ACC_WIDTH=16, votes 32767 then 100 -> accumulator holds 32767; compare uses the saturated value.
REQ-029 i_window_start pulsed during ACCUM and during DONE -> ignored; stage index and outputs unchanged.
REQ-030 reset_fpga low in stage 1 mid-vote -> all outputs take reset values within the same cycle; no o_inspect_done; a new window after release is evaluated correctly.
